// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared VPU constants, opcodes and fetch state encoding
package vpu_pkg;

    localparam int OPER_W  = 5;
    localparam int INSTR_W = 32;

    // IR field slices
    localparam int OPER_MSB = 31;
    localparam int OPER_LSB = 27;

    // Opcodes carried in ir[OPER_MSB:OPER_LSB]
    localparam logic [OPER_W-1:0] OP_MOVSGPR = 5'd0;
    localparam logic [OPER_W-1:0] OP_MOV     = 5'd1;
    localparam logic [OPER_W-1:0] OP_ADD     = 5'd2;
    localparam logic [OPER_W-1:0] OP_SUB     = 5'd3;
    localparam logic [OPER_W-1:0] OP_MUL     = 5'd4;
    localparam logic [OPER_W-1:0] OP_HALT    = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vpu_ifetch_fifo.sv
// rtl/vpu_ifetch_fifo.sv - small prefetch FIFO holding {pc, instruction} pairs
module vpu_ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointer/count update; flush discards everything including a same-cycle push
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; entries reset so the head reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/vpu_ifetch.sv
// rtl/vpu_ifetch.sv - VPU instruction fetch: PC, imem issue, prefetch FIFO, halt/redirect
module vpu_ifetch
    import vpu_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               ir_ready,
    output logic               busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tag_pc_q, tag_pc_d;
    logic            inflight_q, inflight_d;
    logic            tag_epoch_q, tag_epoch_d;
    logic            epoch_q, epoch_d;

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty, fifo_full;
    logic [PC_W+INSTR_W-1:0] fifo_head;

    logic redirect_take, pop, push, halt_push, credit_ok, issue;

    // Redirect only acts once fetch has been started at least once
    assign redirect_take = redirect_valid && (state_q != ST_IDLE);
    assign pop           = !fifo_empty && ir_ready;
    // A return is kept only if no redirect/halt has bumped the epoch since its issue
    assign push          = inflight_q && (tag_epoch_q == epoch_q);
    assign halt_push     = push && (imem_rdata[OPER_MSB:OPER_LSB] == OP_HALT);
    // Credit counts the slot freed by a same-cycle pop so ir_ready=1 sustains one per cycle
    assign credit_ok     = (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));
    assign issue         = (state_q == ST_RUN) && !redirect_valid && credit_ok;

    vpu_ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_take),
        .wdata ({tag_pc_q, imem_rdata}),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect beats halt and start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (redirect_valid) state_d = ST_RUN;
                       else if (halt_push) state_d = ST_HALTED;
            ST_HALTED: if (redirect_valid || start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // PC, epoch and in-flight tag next values
    always_comb begin
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        inflight_d  = issue;
        tag_pc_d    = issue ? pc_q : tag_pc_q;
        tag_epoch_d = issue ? epoch_q : tag_epoch_q;
        if (redirect_take) begin
            pc_d    = redirect_pc;
            epoch_d = ~epoch_q;
        end else if (start && (state_q != ST_RUN)) begin
            pc_d = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 1'b1;
            end
            // Kill the read issued alongside the HALT push
            if (halt_push) begin
                epoch_d = ~epoch_q;
            end
        end
    end

    // PC, epoch and in-flight tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tag_pc_q    <= '0;
            tag_epoch_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epoch_q     <= epoch_d;
            inflight_q  <= inflight_d;
            tag_pc_q    <= tag_pc_d;
            tag_epoch_q <= tag_epoch_d;
        end
    end

    // FSM / datapath outputs
    always_comb begin
        imem_en   = issue;
        imem_addr = pc_q;
        ir_valid  = !fifo_empty;
        ir_pc     = fifo_head[PC_W+INSTR_W-1:INSTR_W];
        ir        = fifo_head[INSTR_W-1:0];
        busy      = (state_q == ST_RUN) || !fifo_empty;
    end

`ifndef SYNTHESIS
    // The credit rule must never let a push land on a full FIFO
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !redirect_take && fifo_full && !pop))
                else $error("fetch FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_vpu_ifetch.sv
// tb/tb_vpu_ifetch.sv - directed self-checking bench for vpu_ifetch
module tb_vpu_ifetch;
    import vpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        ir_valid;
    logic [31:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];

    vpu_ifetch #(.PC_W(8), .INSTR_W(32), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        else         imem_rdata <= 32'h5A5A_5A5A;
    end

    // Expected instruction word at an address: ADD/SUB/MOV rotation, HALT only at 3
    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [4:0] op;
        if (a == 8'd3) op = OP_HALT;
        else if (a % 3 == 0) op = OP_ADD;
        else if (a % 3 == 1) op = OP_SUB;
        else op = OP_MOV;
        return {op, 19'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, ir_valid, 1'b1);
        chk({tag, "_pc"}, ir_pc, pc);
        chk({tag, "_ir"}, ir, word_at(pc));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_at(i[7:0]);
        imem_rdata     = 32'h0;
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        ir_ready       = 1'b1;

        // Reset state
        cyc(); #1;
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_imem_en", imem_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 8'h0);
        chk("rst_imem_addr", imem_addr, 8'h0);
        cyc(); rst_n = 1'b1;

        // 1: start, program 0..3 ending in HALT
        cyc(); start = 1'b1; #1;
        chk("t1_idle_no_issue", imem_en, 1'b0);
        cyc(); start = 1'b0; #1;
        chk("t1_issue0_en", imem_en, 1'b1);
        chk("t1_issue0_addr", imem_addr, 8'h00);
        chk("t1_busy", busy, 1'b1);
        chk("t1_no_ir_yet", ir_valid, 1'b0);
        cyc(); #1;
        chk("t1_still_no_ir", ir_valid, 1'b0);
        chk("t1_issue1_addr", imem_addr, 8'h01);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk_ir("t1_seq", k[7:0]);
        end
        chk("t1_halted_no_issue", imem_en, 1'b0);
        chk("t1_busy_halt_held", busy, 1'b1);
        cyc(); #1;
        chk("t1_after_halt_valid", ir_valid, 1'b0);
        chk("t1_after_halt_busy", busy, 1'b0);
        chk("t1_after_halt_en", imem_en, 1'b0);

        // 2: back-pressure for 10 cycles after redirect from HALTED to 0x10
        cyc(); ir_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h10; #1;
        chk("t2_redirect_cycle_en", imem_en, 1'b0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("t2_issue10", imem_addr, 8'h10);
        chk("t2_issue10_en", imem_en, 1'b1);
        cyc(); #1;
        chk("t2_issue11", imem_addr, 8'h11);
        cyc();
        for (int i = 4; i < 10; i++) begin
            cyc(); #1;
            chk_ir("t2_hold", 8'h10);
            chk("t2_hold_no_issue", imem_en, 1'b0);
        end
        cyc(); ir_ready = 1'b1; #1;
        chk_ir("t2_resume", 8'h10);
        chk("t2_resume_issue_en", imem_en, 1'b1);
        chk("t2_resume_issue_addr", imem_addr, 8'h12);
        for (int i = 1; i < 6; i++) begin
            cyc(); #1;
            chk_ir("t2_stream", 8'h10 + i[7:0]);
        end

        // 3: redirect to 0x40 with a read in flight
        cyc(); ir_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40; #1;
        chk("t3_redirect_no_issue", imem_en, 1'b0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("t3_flushed", ir_valid, 1'b0);
        chk("t3_issue40_en", imem_en, 1'b1);
        chk("t3_issue40_addr", imem_addr, 8'h40);
        cyc(); #1;
        chk("t3_stale_dropped", ir_valid, 1'b0);
        cyc(); #1;
        chk_ir("t3_first", 8'h40);

        // 4: redirect in the same cycle PC 5 is popped
        cyc(); redirect_valid = 1'b1; redirect_pc = 8'h05; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("t4_issue5", imem_addr, 8'h05);
        cyc(); #1;
        cyc(); ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80; #1;
        chk_ir("t4_pop5", 8'h05);
        chk("t4_redirect_no_issue", imem_en, 1'b0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("t4_no_dup5", ir_valid, 1'b0);
        chk("t4_issue80", imem_addr, 8'h80);
        cyc(); #1;
        chk("t4_empty", ir_valid, 1'b0);
        cyc(); #1;
        chk_ir("t4_first80", 8'h80);

        // 5: PC wraps from 0xFF to 0x00 without a stall
        cyc(); redirect_valid = 1'b1; redirect_pc = 8'hFE; #1;
        cyc(); redirect_valid = 1'b0; #1;
        chk("t5_issue_fe", imem_addr, 8'hFE);
        cyc(); #1;
        chk("t5_issue_ff", imem_addr, 8'hFF);
        cyc(); #1;
        chk("t5_issue_00_en", imem_en, 1'b1);
        chk("t5_issue_00", imem_addr, 8'h00);
        chk_ir("t5_ir_fe", 8'hFE);
        cyc(); #1;
        chk_ir("t5_ir_ff", 8'hFF);
        chk("t5_issue_01", imem_addr, 8'h01);
        cyc(); ir_ready = 1'b0; #1;
        chk_ir("t5_ir_00", 8'h00);

        // 6: reset with the FIFO full
        cyc(); #1;
        chk_ir("t6_full_head", 8'h00);
        chk("t6_full_no_issue", imem_en, 1'b0);
        cyc(); rst_n = 1'b0; #1;
        chk("t6_rst_valid", ir_valid, 1'b0);
        chk("t6_rst_en", imem_en, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ir", ir, 32'h0);
        cyc(); rst_n = 1'b1;
        cyc(); start = 1'b1; ir_ready = 1'b1; #1;
        chk("t6_idle_en", imem_en, 1'b0);
        cyc(); start = 1'b0; #1;
        chk("t6_restart_en", imem_en, 1'b1);
        chk("t6_restart_addr", imem_addr, 8'h00);
        cyc(); #1;
        cyc(); #1;
        chk_ir("t6_restart_ir", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
